// File: rtl/mips_instr_encoder_if.sv
// Field-beat input channel, imem write port and loader status of the MIPS instruction encoder.
// The loader (bench or boot ROM) drives the master side; the encoder owns the slave side.
interface mips_instr_encoder_if #(
    parameter int unsigned ADDR_W = 6
) ();
    logic              start;
    logic              finish;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [ADDR_W-1:0] in_target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic              busy;

    modport master (
        output start, finish, in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
        input  in_ready, imem_we, imem_addr, imem_wdata, count, full, err, busy
    );

    modport slave (
        input  start, finish, in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
        output in_ready, imem_we, imem_addr, imem_wdata, count, full, err, busy
    );
endinterface

// File: rtl/mips_instr_encoder.sv
// Encodes decoded MIPS fields into instruction words and streams them into imem, one per cycle.
// Branch offsets and jump fields are derived from absolute word-index targets.
module mips_instr_encoder #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input logic                 clk,
    input logic                 rst_n,
    mips_instr_encoder_if.slave bus
);
    localparam logic [ADDR_W:0] CountMax = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CountOne = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

    typedef enum logic [2:0] {
        KindR, KindAddi, KindLw, KindSw, KindBeq, KindBne, KindJ, KindIllegal
    } kind_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              full;
    logic              ready;
    logic              accept;
    kind_e             kind;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   off_full;
    logic [15:0]       off16;
    logic [31:0]       enc_word;

    // Write pointer always equals the word count, so the count doubles as the pointer.
    assign ptr    = count_q[ADDR_W-1:0];
    assign full   = (count_q == CountMax);
    assign ready  = (state_q == StLoad) && !bus.start && !full;
    assign accept = bus.in_valid && ready;
    assign kind   = kind_e'(bus.in_kind);

    // Branch offset is relative to the word after the branch, in ADDR_W+1 bit two's complement.
    assign off_full = {1'b0, bus.in_target} - {1'b0, ptr} - CountOne;

    if (ADDR_W + 1 >= 16) begin : g_off_trunc
        assign off16 = off_full[15:0];
    end else begin : g_off_sext
        assign off16 = {{(15 - ADDR_W){off_full[ADDR_W]}}, off_full};
    end

    always_comb begin
        enc_word = 32'h0;
        unique case (kind)
            KindR:    enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, bus.in_funct};
            KindAddi: enc_word = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
            KindLw:   enc_word = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
            KindSw:   enc_word = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm};
            KindBeq:  enc_word = {6'h04, bus.in_rs, bus.in_rt, off16};
            KindBne:  enc_word = {6'h05, bus.in_rs, bus.in_rt, off16};
            KindJ:    enc_word = {6'h02, 26'(bus.in_target)};
            default:  enc_word = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            StIdle: begin
            end
            StLoad: begin
                if (accept) begin
                    if (kind == KindIllegal) begin
                        err_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = ptr;
                        wdata_d = enc_word;
                        count_d = count_q + CountOne;
                        if (count_d == CountMax) begin
                            state_d = StFull;
                        end
                    end
                end
                // A beat accepted alongside finish is still written before going idle.
                if (bus.finish) begin
                    state_d = StIdle;
                end
            end
            StFull: begin
                if (bus.finish) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus.start) begin
            state_d = StLoad;
            count_d = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.count      = count_q;
    assign bus.full       = full;
    assign bus.err        = err_q;
    assign bus.busy       = (state_q != StIdle);
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed scenarios plus a randomized run,
// all compared against a transaction-level model of the loader.
module tb_mips_instr_encoder;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 4;

    logic clk;
    logic rst_n;

    mips_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    mips_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: loader active flag, words written, sticky error and the last write seen on imem.
    bit          m_active;
    int          m_count;
    bit          m_err;
    bit          m_we;
    int          m_addr;
    logic [31:0] m_wdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_enc(input int k, input int rs, input int rt, input int rd,
                                            input int fn, input int imm, input int tgt,
                                            input int p);
        logic [31:0] hi;
        int          off;
        off = tgt - (p + 1);
        hi  = (32'(rs) << 21) | (32'(rt) << 16);
        case (k)
            0:       return hi | (32'(rd) << 11) | 32'(fn);
            1:       return (32'h08 << 26) | hi | 32'(imm);
            2:       return (32'h23 << 26) | hi | 32'(imm);
            3:       return (32'h2B << 26) | hi | 32'(imm);
            4:       return (32'h04 << 26) | hi | (32'(off) & 32'hFFFF);
            5:       return (32'h05 << 26) | hi | (32'(off) & 32'hFFFF);
            6:       return (32'h02 << 26) | 32'(tgt);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_count  = 0;
        m_err    = 0;
        m_we     = 0;
        m_addr   = 0;
        m_wdata  = 32'h0;
    endtask

    task automatic check_outputs();
        check_eq("imem_we", bus.imem_we, m_we);
        check_eq("imem_addr", bus.imem_addr, m_addr);
        check_eq("imem_wdata", bus.imem_wdata, m_wdata);
        check_eq("count", bus.count, m_count);
        check_eq("full", bus.full, m_count == DEPTH);
        check_eq("err", bus.err, m_err);
        check_eq("busy", bus.busy, m_active);
    endtask

    task automatic drive_ctl(input bit s, input bit f);
        bus.start    = s;
        bus.finish   = f;
        bus.in_valid = 1'b0;
    endtask

    task automatic drive_beat(input int k, input int rs, input int rt, input int rd, input int fn,
                              input int imm, input int tgt);
        bus.start     = 1'b0;
        bus.finish    = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_kind   = 3'(k);
        bus.in_rs     = 5'(rs);
        bus.in_rt     = 5'(rt);
        bus.in_rd     = 5'(rd);
        bus.in_funct  = 6'(fn);
        bus.in_imm    = 16'(imm);
        bus.in_target = ADDR_W'(tgt);
    endtask

    // One clock: check in_ready against the model, advance the model, compare registered outputs.
    task automatic step();
        bit rdy;
        #1;
        rdy = m_active && !bus.start && (m_count < DEPTH);
        check_eq("in_ready", bus.in_ready, rdy);
        if (bus.start) begin
            m_active = 1;
            m_count  = 0;
            m_err    = 0;
            m_we     = 0;
        end else begin
            m_we = 0;
            if (rdy && bus.in_valid) begin
                if (bus.in_kind == 3'd7) begin
                    m_err = 1;
                end else begin
                    m_we    = 1;
                    m_addr  = m_count;
                    m_wdata = ref_enc(int'(bus.in_kind), int'(bus.in_rs), int'(bus.in_rt),
                                      int'(bus.in_rd), int'(bus.in_funct), int'(bus.in_imm),
                                      int'(bus.in_target), m_count);
                    m_count++;
                end
            end
            if (bus.finish) m_active = 0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0;
        drive_beat(0, 0, 0, 0, 0, 0, 0);
        drive_ctl(1'b0, 1'b0);
        model_reset();
        #12;
        check_outputs();
        check_eq("rst_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First word after start.
        drive_ctl(1'b1, 1'b0); step();
        drive_beat(1, 0, 8, 0, 0, 5, 0); step();
        check_eq("addi_wdata", bus.imem_wdata, 32'h20080005);
        check_eq("addi_count", bus.count, 1);

        // Back-to-back beats, one strobe per cycle.
        drive_ctl(1'b1, 1'b0); step();
        drive_beat(0, 9, 10, 8, 'h20, 0, 0); step();
        check_eq("r_wdata", bus.imem_wdata, 32'h012A4020);
        drive_beat(2, 29, 8, 0, 0, 4, 0); step();
        check_eq("lw_wdata", bus.imem_wdata, 32'h8FA80004);
        check_eq("lw_we", bus.imem_we, 1'b1);
        drive_beat(6, 0, 0, 0, 0, 0, 0); step();
        check_eq("j_wdata", bus.imem_wdata, 32'h08000000);
        check_eq("j_addr", bus.imem_addr, 2);

        // Backward and forward branch offsets.
        drive_ctl(1'b1, 1'b0); step();
        for (int i = 0; i < 3; i++) begin
            drive_beat(1, i, i, 0, 0, i, 0); step();
        end
        drive_beat(4, 8, 9, 0, 0, 0, 1); step();
        check_eq("beq_wdata", bus.imem_wdata, 32'h1109FFFD);
        check_eq("beq_addr", bus.imem_addr, 3);
        drive_beat(5, 8, 9, 0, 0, 0, 10); step();
        check_eq("bne_wdata", bus.imem_wdata, 32'h15090005);

        // Illegal kind: accepted, no write, sticky err until start.
        drive_ctl(1'b1, 1'b0); step();
        drive_beat(1, 1, 2, 0, 0, 3, 0); step();
        drive_beat(1, 1, 2, 0, 0, 4, 0); step();
        drive_beat(7, 1, 2, 0, 0, 5, 0); step();
        check_eq("ill_err", bus.err, 1'b1);
        check_eq("ill_we", bus.imem_we, 1'b0);
        check_eq("ill_count", bus.count, 2);
        drive_beat(1, 3, 4, 0, 0, 6, 0); step();
        check_eq("ill_next_addr", bus.imem_addr, 2);
        drive_ctl(1'b1, 1'b0); step();
        check_eq("start_clr_err", bus.err, 1'b0);

        // Fill to DEPTH; a held beat must not be accepted afterwards.
        for (int i = 0; i < DEPTH; i++) begin
            drive_beat(3, i, i + 1, 0, 0, i * 4, 0); step();
        end
        check_eq("full_flag", bus.full, 1'b1);
        check_eq("full_last_addr", bus.imem_addr, DEPTH - 1);
        check_eq("full_ready", bus.in_ready, 1'b0);
        step();
        step();
        bus.start = 1'b1; step();
        check_eq("restart_count", bus.count, 0);
        drive_beat(1, 5, 6, 0, 0, 7, 0); step();

        // start beats valid data in the same cycle.
        drive_beat(1, 5, 6, 0, 0, 8, 0);
        bus.start = 1'b1; step();
        check_eq("prio_no_we", bus.imem_we, 1'b0);

        // finish with an accepted beat: write lands, loader goes idle.
        drive_beat(0, 1, 2, 3, 'h22, 0, 0);
        bus.finish = 1'b1; step();
        check_eq("fin_busy", bus.busy, 1'b0);
        drive_beat(1, 1, 1, 0, 0, 1, 0); step();

        // Reset right after an accept cancels the pending strobe at once.
        drive_ctl(1'b1, 1'b0); step();
        drive_beat(1, 2, 3, 0, 0, 9, 0); step();
        drive_ctl(1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_mid_we", bus.imem_we, 1'b0);
        check_eq("rst_mid_busy", bus.busy, 1'b0);
        check_outputs();
        #1;
        rst_n = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            drive_beat($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
                       $urandom_range(0, (1 << ADDR_W) - 1));
            bus.in_valid = ($urandom_range(0, 99) < 75);
            bus.start    = ($urandom_range(0, 99) < 5);
            bus.finish   = ($urandom_range(0, 99) < 4);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
